// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: byte-addressable RAM with configurable wait states and ERROR response for misaligned/oversized beats.
// Latency: data phase completes P_WAIT_NSEQ / P_WAIT_SEQ cycles after the address phase (0 = next cycle); illegal beats take 2 cycles.
// Backpressure: HREADYout is held low during wait states and the first ERROR cycle; no address phase is accepted while it is low.
module ahb_mem_slave #(
    parameter int P_SLV_ID        = 0,
    parameter int P_SIZE_IN_BYTES = 1024,
    parameter int P_WAIT_NSEQ     = 0,
    parameter int P_WAIT_SEQ      = 0,
    parameter int P_ERR_EN        = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADYin,
    output logic [31:0] HRDATA,
    output logic [1:0]  HRESP,
    output logic        HREADYout
);

    localparam int AW    = $clog2(P_SIZE_IN_BYTES);
    localparam int WORDS = P_SIZE_IN_BYTES / 4;
    localparam int WAW   = (AW > 2) ? AW - 2 : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR1 = 2'd2;
    localparam logic [1:0] S_ERR2 = 2'd3;

    localparam logic [3:0] WAIT_NSEQ = 4'(P_WAIT_NSEQ);
    localparam logic [3:0] WAIT_SEQ  = 4'(P_WAIT_SEQ);
    localparam bit         ERR_EN    = (P_ERR_EN != 0);

    logic [1:0]    state;
    logic [3:0]    cnt;

    // Latched address phase
    logic          ph_vld;
    logic [AW-1:0] ph_off;
    logic [2:0]    ph_size;
    logic          ph_write;
    logic          ph_bad;

    logic          accept;
    logic          addr_bad;
    logic [3:0]    wait_n;
    logic          done_ok;
    logic [3:0]    byte_en;
    logic [WAW-1:0] word_idx;

    logic [31:0]   mem [WORDS];

    // HBURST, the upper address bits and the slave index do not affect behaviour
    logic unused_ok;
    assign unused_ok = &{1'b0, HBURST, HADDR[31:AW], P_SLV_ID[0]};

    // Address phase decode: acceptance, legality and wait count for the presented beat
    assign accept   = HSEL & HREADYin & HTRANS[1] & HREADYout;
    assign addr_bad = (HSIZE > 3'd2) ||
                      ((HSIZE == 3'd1) && HADDR[0]) ||
                      ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    assign wait_n   = HTRANS[0] ? WAIT_SEQ : WAIT_NSEQ;

    // Bus responses derived purely from state so HREADYin can be fed back without a loop
    assign HREADYout = (state == S_IDLE) || (state == S_ERR2);
    assign HRESP     = ((state == S_ERR1) || (state == S_ERR2)) ? 2'b01 : 2'b00;

    // A legal data phase completes in any S_IDLE cycle holding a latched beat
    assign done_ok = ph_vld && !ph_bad && (state == S_IDLE);

    generate
        if (AW > 2) begin : g_idx
            assign word_idx = ph_off[AW-1:2];
        end else begin : g_idx1
            assign word_idx = '0;
        end
    endgenerate

    // Byte lanes touched by the latched size and low address bits
    always_comb begin
        byte_en = 4'b0000;
        case (ph_size)
            3'd0:    byte_en = 4'b0001 << ph_off[1:0];
            3'd1:    byte_en = ph_off[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // Read data is only driven during a completing legal read
    assign HRDATA = (done_ok && !ph_write) ? mem[word_idx] : 32'h0;

    // Control FSM, wait counter and address-phase latch
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            ph_vld   <= 1'b0;
            ph_off   <= '0;
            ph_size  <= 3'd0;
            ph_write <= 1'b0;
            ph_bad   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_ERR2: begin
                    ph_vld <= accept;
                    if (accept) begin
                        ph_off   <= HADDR[AW-1:0];
                        ph_size  <= HSIZE;
                        ph_write <= HWRITE;
                        ph_bad   <= addr_bad;
                    end
                    if (accept && addr_bad && ERR_EN) begin
                        state <= S_ERR1;
                    end else if (accept && !addr_bad && (wait_n != 4'd0)) begin
                        state <= S_WAIT;
                        cnt   <= wait_n;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state <= S_IDLE;
                    end
                end
                S_ERR1: begin
                    state <= S_ERR2;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Byte-lane write at the edge that ends a completing legal write; contents survive reset
    always_ff @(posedge HCLK) begin
        if (HRESETn && done_ok && ph_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: three slaves on one shared AHB bus (zero-wait, 3/1 waits, error-disabled).
// Latency: each beat is checked when its data phase completes; wait cycles are counted and compared.
// Backpressure: the master holds address/data while the combined HREADY is low, bounded by a cycle budget.
module tb_ahb_mem_slave;

    logic        HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        HRESETn;
    logic [2:0]  hsel;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [31:0] rdata [3];
    logic [1:0]  resp  [3];
    logic [2:0]  rdy;
    logic        HREADYin;
    logic [31:0] bus_rdata;
    logic [1:0]  bus_resp;

    assign HREADYin  = &rdy;
    assign bus_rdata = rdata[0] | rdata[1] | rdata[2];
    assign bus_resp  = resp[0] | resp[1] | resp[2];

    ahb_mem_slave #(.P_SLV_ID(0), .P_SIZE_IN_BYTES(1024), .P_WAIT_NSEQ(0), .P_WAIT_SEQ(0), .P_ERR_EN(1)) u_s0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADYin(HREADYin),
        .HRDATA(rdata[0]), .HRESP(resp[0]), .HREADYout(rdy[0]));
    ahb_mem_slave #(.P_SLV_ID(1), .P_SIZE_IN_BYTES(1024), .P_WAIT_NSEQ(3), .P_WAIT_SEQ(1), .P_ERR_EN(1)) u_s1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADYin(HREADYin),
        .HRDATA(rdata[1]), .HRESP(resp[1]), .HREADYout(rdy[1]));
    ahb_mem_slave #(.P_SLV_ID(2), .P_SIZE_IN_BYTES(1024), .P_WAIT_NSEQ(0), .P_WAIT_SEQ(0), .P_ERR_EN(0)) u_s2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[2]), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADYin(HREADYin),
        .HRDATA(rdata[2]), .HRESP(resp[2]), .HREADYout(rdy[2]));

    localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;

    typedef struct {
        int          sel;     // 0..2 selects a slave, 3 selects none
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
        logic [31:0] wdata;
        logic [1:0]  trans;
    } beat_t;

    beat_t       q[$];
    logic [7:0]  mdl [3][1024];
    int          vectors     = 0;
    int          miscompares = 0;

    function automatic int cfg_nseq(int d); return (d == 1) ? 3 : 0; endfunction
    function automatic int cfg_seq(int d);  return (d == 1) ? 1 : 0; endfunction
    function automatic bit cfg_err(int d);  return (d != 2);         endfunction

    function automatic logic [31:0] mdl_word(int d, int off);
        int w = off - (off % 4);
        return {mdl[d][w+3], mdl[d][w+2], mdl[d][w+1], mdl[d][w]};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_addr(beat_t b);
        hsel   = (b.sel < 3) ? (3'b001 << b.sel) : 3'b000;
        HADDR  = b.addr;
        HTRANS = b.trans;
        HWRITE = b.wr;
        HSIZE  = b.size;
        HBURST = 3'($urandom_range(0, 7));
    endtask

    task automatic drive_idle();
        hsel   = 3'b000;
        HTRANS = T_IDLE;
        HWRITE = 1'b0;
        HSIZE  = 3'd0;
        HADDR  = 32'h0;
    endtask

    function automatic beat_t mk(int sel, logic [31:0] addr, logic [2:0] size, logic wr,
                                 logic [31:0] wdata, logic [1:0] trans);
        beat_t b;
        b.sel = sel; b.addr = addr; b.size = size; b.wr = wr; b.wdata = wdata; b.trans = trans;
        return b;
    endfunction

    function automatic beat_t rnd_beat();
        beat_t b;
        int r, off;
        r       = $urandom_range(0, 9);
        b.sel   = (r < 9) ? (r % 3) : 3;
        r       = $urandom_range(0, 7);
        b.trans = (r == 0) ? T_IDLE : (r == 1) ? T_BUSY : (r < 5) ? T_NSEQ : T_SEQ;
        r       = $urandom_range(0, 9);
        b.size  = (r < 9) ? 3'(r % 3) : 3'd3;
        off     = $urandom_range(0, 255);
        if ($urandom_range(0, 9) == 0) off = 1020 + (off % 4);
        if (b.size <= 3'd2 && $urandom_range(0, 4) != 0) off = off - (off % (1 << b.size));
        b.addr  = ($urandom() & 32'hFFFF_FC00) | 32'(off);
        b.wr    = 1'($urandom_range(0, 1));
        b.wdata = $urandom();
        return b;
    endfunction

    // Pipelined master: address phase of beat i+1 overlaps data phase of beat i
    task automatic run_q();
        int n = q.size();
        if (n == 0) return;
        drive_addr(q[0]);
        for (int i = 0; i < n; i++) begin
            beat_t       b = q[i];
            int          waits = 0;
            logic [1:0]  wresp = 2'b00;
            logic [1:0]  fresp;
            logic [31:0] frd;
            int          d, off, ew, nb;
            logic [1:0]  ewr, efr;
            logic [31:0] erd;
            bit          act, bad;
            @(posedge HCLK); #1;
            HWDATA = b.wdata;
            if (i + 1 < n) drive_addr(q[i+1]); else drive_idle();
            forever begin
                @(negedge HCLK);
                if (HREADYin) break;
                if (waits == 0) wresp = bus_resp;
                waits++;
                if (waits > 40) begin
                    chk("ready_timeout", {31'b0, HREADYin}, 32'd1);
                    break;
                end
            end
            fresp = bus_resp;
            frd   = bus_rdata;
            // Expected response from the access rules
            d   = b.sel;
            off = int'(b.addr & 32'h3FF);
            act = (d < 3) && b.trans[1];
            bad = (b.size > 3'd2) || (b.size == 3'd1 && (off % 2) != 0) || (b.size == 3'd2 && (off % 4) != 0);
            ew = 0; ewr = 2'b00; efr = 2'b00; erd = 32'h0;
            if (act && bad) begin
                if (cfg_err(d)) begin ew = 1; ewr = 2'b01; efr = 2'b01; end
            end else if (act) begin
                ew = (b.trans == T_SEQ) ? cfg_seq(d) : cfg_nseq(d);
                if (!b.wr) erd = mdl_word(d, off);
            end
            chk("wait_cycles", 32'(waits), 32'(ew));
            if (ew > 0 && waits > 0) chk("wait_resp", {30'b0, wresp}, {30'b0, ewr});
            chk("final_resp", {30'b0, fresp}, {30'b0, efr});
            chk("rdata", frd, erd);
            if (act && !bad && b.wr) begin
                nb = 1 << b.size;
                for (int k = 0; k < nb; k++)
                    mdl[d][off+k] = b.wdata[8*((off+k)%4) +: 8];
            end
        end
        q.delete();
    endtask

    initial begin
        HRESETn = 1'b0;
        HWDATA  = 32'h0;
        HBURST  = 3'd0;
        drive_idle();

        // Reset state
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("reset_ready", {29'b0, rdy}, 32'h7);
        chk("reset_resp", {26'b0, resp[0], resp[1], resp[2]}, 32'h0);
        chk("reset_rdata", bus_rdata, 32'h0);
        HRESETn = 1'b1;

        // Fill the used window of every slave with random words
        for (int d = 0; d < 3; d++) begin
            for (int w = 0; w < 65; w++) begin
                int o = (w < 64) ? w * 4 : 1020;
                q.push_back(mk(d, 32'(o), 3'd2, 1'b1, $urandom(), (w == 0) ? T_NSEQ : T_SEQ));
            end
        end
        run_q();

        // Zero-wait word write then read of 0x10
        q.push_back(mk(0, 32'h10, 3'd2, 1'b1, 32'hDEADBEEF, T_NSEQ));
        q.push_back(mk(0, 32'h10, 3'd2, 1'b0, 32'h0, T_NSEQ));
        run_q();
        chk("deadbeef_model", mdl_word(0, 16), 32'hDEADBEEF);

        // Byte write 0xAA at 0x11 over 0x11223344 (byte replicated on all lanes)
        q.push_back(mk(0, 32'h10, 3'd2, 1'b1, 32'h11223344, T_NSEQ));
        q.push_back(mk(0, 32'h11, 3'd0, 1'b1, 32'hAAAAAAAA, T_NSEQ));
        q.push_back(mk(0, 32'h10, 3'd2, 1'b0, 32'h0, T_NSEQ));
        run_q();
        chk("byte_merge_model", mdl_word(0, 16), 32'h1122AA44);

        // 4-beat INCR read on the wait-state slave: 3 then 1,1,1 wait cycles
        q.push_back(mk(1, 32'h20, 3'd2, 1'b0, 32'h0, T_NSEQ));
        for (int k = 1; k < 4; k++) q.push_back(mk(1, 32'(32'h20 + 4 * k), 3'd2, 1'b0, 32'h0, T_SEQ));
        run_q();

        // Misaligned word write: ERROR on slave 0, silent OKAY on slave 2; memory unchanged in both
        q.push_back(mk(0, 32'h12, 3'd2, 1'b1, 32'h55555555, T_NSEQ));
        q.push_back(mk(0, 32'h10, 3'd2, 1'b0, 32'h0, T_NSEQ));
        q.push_back(mk(2, 32'h12, 3'd2, 1'b1, 32'h66666666, T_NSEQ));
        q.push_back(mk(2, 32'h10, 3'd2, 1'b0, 32'h0, T_NSEQ));
        run_q();

        // BUSY between SEQ beats: zero-wait OKAY and no write of its data
        q.push_back(mk(0, 32'h40, 3'd2, 1'b1, 32'hA5A5A5A5, T_NSEQ));
        q.push_back(mk(0, 32'h44, 3'd2, 1'b1, 32'hFFFFFFFF, T_BUSY));
        q.push_back(mk(0, 32'h44, 3'd2, 1'b1, 32'h5A5A5A5A, T_SEQ));
        q.push_back(mk(0, 32'h48, 3'd2, 1'b1, 32'h0BADF00D, T_BUSY));
        q.push_back(mk(0, 32'h48, 3'd2, 1'b0, 32'h0, T_NSEQ));
        q.push_back(mk(0, 32'h44, 3'd2, 1'b0, 32'h0, T_NSEQ));
        run_q();

        // Reset during the wait states of a write aborts it
        @(posedge HCLK); #1;
        drive_addr(mk(1, 32'h30, 3'd2, 1'b1, 32'h0, T_NSEQ));
        @(posedge HCLK); #1;
        HWDATA = 32'hCAFEF00D;
        drive_idle();
        @(negedge HCLK);
        chk("abort_in_wait", {31'b0, HREADYin}, 32'd0);
        HRESETn = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("abort_ready", {31'b0, HREADYin}, 32'd1);
        chk("abort_resp", {30'b0, bus_resp}, 32'd0);
        chk("abort_rdata", bus_rdata, 32'h0);
        q.push_back(mk(1, 32'h30, 3'd2, 1'b0, 32'h0, T_NSEQ));
        run_q();

        // Randomized pipelined traffic across all slaves
        for (int k = 0; k < 400; k++) q.push_back(rnd_beat());
        run_q();

        // Read back the whole window of every slave
        for (int d = 0; d < 3; d++)
            for (int w = 0; w < 64; w++)
                q.push_back(mk(d, 32'(w * 4), 3'd2, 1'b0, 32'h0, T_SEQ));
        run_q();

        repeat (2) @(posedge HCLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
